// File: rtl/regfile_sb.sv
// Register file with two read ports, two prioritised write ports, hardwired r0 and a
// write-back scoreboard (per-register busy bits, busy counter, stall). Optional macro: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter  int NREGS  = 32,
  parameter  int DWIDTH = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [AW-1:0]     rsel0,
  input  logic [AW-1:0]     rsel1,
  output logic [DWIDTH-1:0] rdat0,
  output logic [DWIDTH-1:0] rdat1,
  input  logic              wen0,
  input  logic [AW-1:0]     wsel0,
  input  logic [DWIDTH-1:0] wdat0,
  input  logic              wen1,
  input  logic [AW-1:0]     wsel1,
  input  logic [DWIDTH-1:0] wdat1,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_sel,
  output logic              busy0,
  output logic              busy1,
  output logic              stall,
  output logic [AW:0]       busy_cnt
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [AW:0]       cnt_q, cnt_d;

  logic [NREGS-1:0]  wr_mask;
  logic [NREGS-1:0]  rsv_mask;
  logic [AW:0]       set_n;
  logic [AW:0]       clr_n;

  // Decode write/reserve targets; bit 0 is never a target so r0 stays zero and idle.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    wr_mask  = '0;
    rsv_mask = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_mask[i]  = (wen0 && (wsel0 == AW'(i))) || (wen1 && (wsel1 == AW'(i)));
      rsv_mask[i] = rsv_en && (rsv_sel == AW'(i));
    end
  end

  // Reserve beats a same-cycle write; counter tracks only real 0->1 and 1->0 transitions.
  always_comb begin
    busy_d = (busy_q & ~wr_mask) | rsv_mask;
    set_n  = '0;
    clr_n  = '0;
    for (int i = 0; i < NREGS; i++) begin
      set_n = set_n + {{AW{1'b0}}, rsv_mask[i] & ~busy_q[i]};
      clr_n = clr_n + {{AW{1'b0}}, wr_mask[i] & busy_q[i] & ~rsv_mask[i]};
    end
    cnt_d = cnt_q + set_n - clr_n;
  end

  // NOTE: the array is reset because architectural state must read 0 after reset; state uses <= only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wen1 && (wsel1 == AW'(i)))      regs_q[i] <= wdat1;
        else if (wen0 && (wsel0 == AW'(i))) regs_q[i] <= wdat0;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rdat0 = regs_q[rsel0];
    rdat1 = regs_q[rsel1];
    busy0 = busy_q[rsel0];
    busy1 = busy_q[rsel1];
`ifdef REGFILE_BYPASS_EN
    // Write-first forwarding, port 1 over port 0; gated so nothing leaks out during reset.
    if (rsel0 != '0) begin
      if (wen1 && (wsel1 == rsel0))      rdat0 = wdat1;
      else if (wen0 && (wsel0 == rsel0)) rdat0 = wdat0;
    end
    if (rsel1 != '0) begin
      if (wen1 && (wsel1 == rsel1))      rdat1 = wdat1;
      else if (wen0 && (wsel0 == rsel1)) rdat1 = wdat0;
    end
    if (wr_mask[rsel0] && !rsv_mask[rsel0]) busy0 = 1'b0;
    if (wr_mask[rsel1] && !rsv_mask[rsel1]) busy1 = 1'b0;
    if (!nRST) begin
      rdat0 = '0;
      rdat1 = '0;
    end
`endif
    stall = busy0 | busy1;
  end

  assign busy_cnt = cnt_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with a write-back scoreboard, the next generation of the single-write-port register bank. It provides two read ports, two prioritised write ports and a hardwired zero register. Per-register busy bits track in-flight producers, and a busy counter reports outstanding writes. It sits in decode/write-back and gives the hazard unit a direct stall signal.

Parameters:
NREGS, 32, number of architectural registers (power of two, >= 4)
DWIDTH, 32, register data width
AW, $clog2(NREGS), address width (derived; do not override)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
rsel0  in  AW  read port 0 address
rsel1  in  AW  read port 1 address
rdat0  out  DWIDTH  read port 0 data
rdat1  out  DWIDTH  read port 1 data
wen0  in  1  write port 0 enable
wsel0  in  AW  write port 0 address
wdat0  in  DWIDTH  write port 0 data
wen1  in  1  write port 1 enable (higher priority)
wsel1  in  AW  write port 1 address
wdat1  in  DWIDTH  write port 1 data
rsv_en  in  1  reserve destination (mark busy)
rsv_sel  in  AW  register to reserve
busy0  out  1  rsel0 register is busy
busy1  out  1  rsel1 register is busy
stall  out  1  busy0 | busy1
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset, asynchronous on nRST low: all registers 0, all busy bits 0, busy_cnt 0. Every output reads 0 during reset.
- Register 0 always reads 0 and is never busy. Writes and reserves addressed to 0 are ignored and have no effect on busy_cnt.
- Reads are combinational from the array. Write latency is 1 cycle: data is visible on rdat the cycle after wen.
- Both writes to the same address in one cycle: port 1 wins. Writes to different addresses both commit.
- Busy bit set: rsv_en high at an edge sets busy[rsv_sel].
- Busy bit clear: a committed write to a register clears its busy bit.
- Reserve and write to the same register in the same cycle: the reserve wins and busy stays 1. The data still commits, because a new producer has been issued.
- Reserve of an already-busy register: the bit stays 1 and busy_cnt does not change.
- A write to a non-busy register is legal: data commits and busy_cnt does not change.
- busy_cnt is registered and equals the popcount of the busy bits after each edge. It is updated incrementally: +1 per newly set bit, -1 per newly cleared bit. Two clears and one set in one cycle gives a net -1. It never underflows and never exceeds NREGS-1.
- busy0, busy1 and stall are combinational from the busy bits and the current rsel. They reflect the state before the current edge and are not bypassed.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If wenX is active and wselX == rselY != 0, rdatY = wdatX in the same cycle, with port 1 taking priority over port 0. busyY is also forced 0 when a same-cycle write to rselY clears it and no reserve to that register occurs. This removes one stall cycle.
- Undefined: reads return stored values only, and written data appears the next cycle.

Test Plan:
1. Reset, then read every address -> all rdat 0 and busy_cnt 0. Assert nRST mid-run with registers populated -> outputs go to 0 immediately, without waiting for a clock edge.
2. Write r5=0xDEADBEEF on port 0 and, in the same cycle, r5=0x12345678 on port 1 -> next cycle rdat0(rsel0=5)=0x12345678. Write r0=0xFFFFFFFF -> r0 reads 0.
3. Reserve r7 -> next cycle busy0=1 for rsel0=7, stall=1, busy_cnt=1. Write r7=0xA5 -> next cycle busy0=0, busy_cnt=0, rdat0=0xA5.
4. Reserve r3 and write r3=0x11 in the same cycle -> r3=0x11 and busy stays 1. Reserve r3 again -> busy_cnt unchanged. Reserve r0 -> busy_cnt unchanged.
5. Reserve r1, r2, r4 -> busy_cnt=3. Then in one cycle write r1 and r2 and reserve r6 -> busy_cnt=2.
6. With REGFILE_BYPASS_EN: write r9=0x55 with rsel1=9 in the same cycle -> rdat1=0x55 that cycle. Without the macro -> rdat1 shows the old value that cycle and 0x55 the next cycle.
